// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: eviction-buffer drain states and the legacy
// single-entry eviction record.
package lc3b_types;

    typedef enum logic {
        ev_idle,
        ev_write
    } lc3b_evict_state;

    // Fixed-width entry kept for DEPTH=1 users; parametrised buffers keep their own arrays.
    typedef struct packed {
        logic         valid;
        logic         dirty;
        logic [15:0]  addr;
        logic [127:0] data;
    } lc3b_eviction_array_entry;

endpackage

// File: rtl/evict_tag_match.sv
// DEPTH-way fully-associative line-address comparator: one-hot match vector
// plus the encoded index of the (at most one) matching valid entry.
module evict_tag_match #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 16,
    parameter int OFFSET_W = 5
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] addrs,
    input  logic [ADDR_W-1:0]            query,
    output logic [DEPTH-1:0]             match,
    output logic [$clog2(DEPTH)-1:0]     index
);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        match = '0;
        index = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Offset bits are shifted out so only the line address is compared.
            if (valid[i] && (((addrs[i] ^ query) >> OFFSET_W) == '0)) begin
                match[i] = 1'b1;
                index    = ($clog2(DEPTH))'(i);
            end
        end
    end

endmodule

// File: rtl/eviction_write_buffer.sv
// Ring-ordered victim/write-back buffer: accepts evicted lines, serves
// associative lookups with reclaim, and drains dirty lines to memory in order.
module eviction_write_buffer
    import lc3b_types::*;
#(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 16,
    parameter int LINE_W   = 256,
    parameter int OFFSET_W = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     evict_valid,
    output logic                     evict_ready,
    input  logic                     evict_dirty,
    input  logic [ADDR_W-1:0]        evict_addr,
    input  logic [LINE_W-1:0]        evict_data,
    input  logic [ADDR_W-1:0]        lookup_addr,
    output logic                     lookup_hit,
    output logic [LINE_W-1:0]        lookup_data,
    output logic                     lookup_dirty,
    input  logic                     lookup_take,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_W-1:0]        mem_wdata,
    input  logic                     mem_resp,
    output logic [$clog2(DEPTH):0]   used,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0]             dirty_q;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0]            data_q [DEPTH];
    logic [PTR_W-1:0]             head_q, tail_q;
    logic [CNT_W-1:0]             used_q;
    lc3b_evict_state              state_q, state_d;

    logic             push, pop, take, start_write, ev_hit;
    logic [DEPTH-1:0] lk_match, ev_match;
    logic [PTR_W-1:0] lk_idx, ev_idx;

    evict_tag_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) u_lookup_match (
        .valid (valid_q),
        .addrs (addr_q),
        .query (lookup_addr),
        .match (lk_match),
        .index (lk_idx)
    );

    evict_tag_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) u_evict_match (
        .valid (valid_q),
        .addrs (addr_q),
        .query (evict_addr),
        .match (ev_match),
        .index (ev_idx)
    );

    assign ev_hit       = |ev_match;
    assign lookup_hit   = |lk_match;
    assign lookup_data  = lookup_hit ? data_q[lk_idx] : '0;
    assign lookup_dirty = lookup_hit & dirty_q[lk_idx];

    assign empty       = (used_q == '0);
    assign used        = used_q;
    assign evict_ready = (used_q < CNT_W'(DEPTH));
    assign mem_write   = (state_q == ev_write);
    assign push        = evict_valid & evict_ready;
    assign take        = lookup_take & lookup_hit;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        start_write = 1'b0;
        unique case (state_q)
            ev_idle: begin
                if (!empty) begin
                    if (valid_q[head_q] && dirty_q[head_q]) begin
                        start_write = 1'b1;
                        state_d     = ev_write;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            ev_write: begin
                // The head pops on completion even if it was invalidated mid-write.
                if (mem_resp) begin
                    pop     = 1'b1;
                    state_d = ev_idle;
                end
            end
        endcase
    end

    // Invalidations apply before the push so a same-address push always wins.
    always_comb begin
        valid_d = valid_q;
        if (take)
            valid_d[lk_idx] = 1'b0;
        if (pop)
            valid_d[head_q] = 1'b0;
        if (push) begin
            if (ev_hit)
                valid_d[ev_idx] = 1'b0;
            valid_d[tail_q] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ev_idle;
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            used_q    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            head_q  <= head_q + PTR_W'(pop);
            tail_q  <= tail_q + PTR_W'(push);
            used_q  <= used_q + CNT_W'(push) - CNT_W'(pop);
            if (start_write) begin
                mem_addr  <= addr_q[head_q];
                mem_wdata <= data_q[head_q];
            end
        end
    end

    // NOTE: payload storage carries no reset; the valid bits alone decide whether a slot holds a line.
    always_ff @(posedge clk) begin
        if (push) begin
            dirty_q[tail_q] <= evict_dirty;
            addr_q[tail_q]  <= evict_addr;
            data_q[tail_q]  <= evict_data;
        end
    end

endmodule

// File: tb/tb_eviction_write_buffer.sv
// Self-checking bench for eviction_write_buffer: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_eviction_write_buffer;

    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 16;
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              evict_valid, evict_ready, evict_dirty;
    logic [ADDR_W-1:0] evict_addr;
    logic [LINE_W-1:0] evict_data;
    logic [ADDR_W-1:0] lookup_addr;
    logic              lookup_hit, lookup_dirty, lookup_take;
    logic [LINE_W-1:0] lookup_data;
    logic              mem_write, mem_resp;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [$clog2(DEPTH):0] used;
    logic              empty;

    int checks = 0;
    int errors = 0;

    eviction_write_buffer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFFSET_W(OFFSET_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_dirty(evict_dirty),
        .evict_addr(evict_addr), .evict_data(evict_data),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .lookup_dirty(lookup_dirty), .lookup_take(lookup_take),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
        .used(used), .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference model: the ring as an ordered queue of entries, oldest first.
    typedef struct {
        bit                valid;
        bit                dirty;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } ment_t;

    ment_t             mq[$];
    bit                m_writing;
    logic [ADDR_W-1:0] m_maddr;
    logic [LINE_W-1:0] m_mdata;
    bit                m_hit, m_ldirty;
    logic [LINE_W-1:0] m_ldata;
    int                m_hit_i;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [LINE_W-1:0] wr_data_q[$];

    function automatic bit same_line(logic [ADDR_W-1:0] a, logic [ADDR_W-1:0] b);
        return a[ADDR_W-1:OFFSET_W] == b[ADDR_W-1:OFFSET_W];
    endfunction

    function automatic logic [LINE_W-1:0] pattern(logic [15:0] seed);
        return {16{seed}};
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        return {4'h8, 7'($urandom_range(0, 5)), 5'($urandom)};
    endfunction

    function automatic logic [LINE_W-1:0] rand_data();
        logic [LINE_W-1:0] d;
        for (int i = 0; i < LINE_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_writing = 0;
        m_maddr   = '0;
        m_mdata   = '0;
    endtask

    task automatic model_outputs();
        m_hit   = 0;
        m_ldirty = 0;
        m_ldata = '0;
        m_hit_i = -1;
        foreach (mq[i]) begin
            if (mq[i].valid && same_line(mq[i].addr, lookup_addr)) begin
                m_hit   = 1;
                m_ldirty = mq[i].dirty;
                m_ldata = mq[i].data;
                m_hit_i = i;
            end
        end
    endtask

    // Advances the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit    do_push, do_pop, do_start;
        ment_t e;
        model_outputs();
        do_push  = evict_valid && (mq.size() < DEPTH);
        do_pop   = 0;
        do_start = 0;
        if (m_writing)
            do_pop = mem_resp;
        else if (mq.size() > 0) begin
            if (mq[0].valid && mq[0].dirty) do_start = 1;
            else do_pop = 1;
        end
        if (do_start) begin
            m_maddr = mq[0].addr;
            m_mdata = mq[0].data;
        end
        if (lookup_take && m_hit) mq[m_hit_i].valid = 0;
        if (do_push)
            foreach (mq[i]) if (same_line(mq[i].addr, evict_addr)) mq[i].valid = 0;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            e.valid = 1;
            e.dirty = evict_dirty;
            e.addr  = evict_addr;
            e.data  = evict_data;
            mq.push_back(e);
        end
        if (m_writing && mem_resp) m_writing = 0;
        else if (do_start) m_writing = 1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        evict_valid = 0;
        evict_dirty = 0;
        evict_addr  = '0;
        evict_data  = '0;
        lookup_addr = '0;
        lookup_take = 0;
        mem_resp    = 0;
    endtask

    task automatic set_push(input bit dirty, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data);
        evict_valid = 1;
        evict_dirty = dirty;
        evict_addr  = addr;
        evict_data  = data;
    endtask

    task automatic apply_reset();
        drive_idle();
        reset_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
    endtask

    // Acts as memory with a fixed response latency until the buffer is drained.
    task automatic serve_memory(input int latency, input int max_cycles, output bit timed_out);
        int cnt;
        cnt = 0;
        timed_out = 1;
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int c = 0; c < max_cycles; c++) begin
            if (empty && !mem_write) begin
                timed_out = 0;
                break;
            end
            mem_resp = 0;
            if (mem_write) begin
                cnt++;
                if (cnt == latency) begin
                    mem_resp = 1;
                    wr_addr_q.push_back(mem_addr);
                    wr_data_q.push_back(mem_wdata);
                    cnt = 0;
                end
            end
            tick();
        end
        mem_resp = 0;
    endtask

    task automatic test_reset();
        bit seen;
        apply_reset();
        checks++; if (used !== 0 || empty !== 1 || evict_ready !== 1) begin errors++;
            $display("FAIL reset_status: used=%0d empty=%0b ready=%0b expected 0/1/1", used, empty, evict_ready); end
        checks++; if (mem_write !== 0 || mem_addr !== '0 || mem_wdata !== '0 || lookup_hit !== 0) begin errors++;
            $display("FAIL reset_outputs: write=%0b addr=%0h hit=%0b expected all 0", mem_write, mem_addr, lookup_hit); end
        set_push(1, 16'h1240, pattern(16'h1240));
        tick();
        drive_idle();
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (mem_write) seen = 1;
            else tick();
        end
        checks++; if (!seen || mem_addr !== 16'h1240) begin errors++;
            $display("FAIL reset_write_start: write=%0b addr=%0h expected 1/1240", mem_write, mem_addr); end
        #2 reset_n = 0;
        model_reset();
        #1;
        checks++; if (mem_write !== 0 || mem_addr !== '0) begin errors++;
            $display("FAIL reset_midwrite: write=%0b addr=%0h expected 0/0", mem_write, mem_addr); end
        @(negedge clk);
        reset_n = 1;
        lookup_addr = 16'h1240;
        @(negedge clk);
        checks++; if (used !== 0 || empty !== 1 || evict_ready !== 1 || lookup_hit !== 0) begin errors++;
            $display("FAIL reset_release: used=%0d empty=%0b ready=%0b hit=%0b expected 0/1/1/0", used, empty, evict_ready, lookup_hit); end
        drive_idle();
    endtask

    task automatic test_fill_drain();
        logic [ADDR_W-1:0] exp_a[4];
        bit to;
        exp_a = '{16'h0100, 16'h0120, 16'h0140, 16'h0160};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_push(1, exp_a[i], pattern(exp_a[i] ^ 16'h5A5A));
            tick();
        end
        drive_idle();
        checks++; if (used !== 4 || evict_ready !== 0) begin errors++;
            $display("FAIL fill_full: used=%0d ready=%0b expected 4/0", used, evict_ready); end
        serve_memory(3, 200, to);
        checks++; if (to || wr_addr_q.size() != 4) begin errors++;
            $display("FAIL fill_drain_count: writes=%0d timeout=%0b expected 4/0", wr_addr_q.size(), to); end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            checks++; if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== pattern(exp_a[i] ^ 16'h5A5A)) begin errors++;
                $display("FAIL fill_drain_order[%0d]: addr=%0h expected %0h", i, wr_addr_q[i], exp_a[i]); end
        end
        checks++; if (empty !== 1) begin errors++;
            $display("FAIL fill_empty: empty=%0b expected 1", empty); end
    endtask

    task automatic test_clean_take();
        bit wrote;
        apply_reset();
        set_push(0, 16'h0200, pattern(16'hC1EA));
        tick();
        drive_idle();
        lookup_addr = 16'h020A;
        lookup_take = 1;
        #1;
        checks++; if (lookup_hit !== 1 || lookup_dirty !== 0 || lookup_data !== pattern(16'hC1EA)) begin errors++;
            $display("FAIL take_hit: hit=%0b dirty=%0b data=%0h expected 1/0/%0h", lookup_hit, lookup_dirty, lookup_data, pattern(16'hC1EA)); end
        tick();
        lookup_take = 0;
        #1;
        checks++; if (lookup_hit !== 0 || lookup_data !== '0) begin errors++;
            $display("FAIL take_gone: hit=%0b data=%0h expected 0/0", lookup_hit, lookup_data); end
        wrote = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_write) wrote = 1;
            tick();
        end
        checks++; if (wrote || empty !== 1) begin errors++;
            $display("FAIL take_no_write: wrote=%0b empty=%0b expected 0/1", wrote, empty); end
    endtask

    task automatic test_duplicate();
        bit to;
        apply_reset();
        set_push(1, 16'h0F00, pattern(16'h0F0F));
        tick();
        drive_idle();
        tick();
        set_push(1, 16'h0300, pattern(16'hAAAA));
        tick();
        set_push(1, 16'h0300, pattern(16'hBBBB));
        tick();
        drive_idle();
        lookup_addr = 16'h0300;
        #1;
        checks++; if (used !== 3 || lookup_hit !== 1 || lookup_data !== pattern(16'hBBBB)) begin errors++;
            $display("FAIL dup_lookup: used=%0d hit=%0b data=%0h expected 3/1/B", used, lookup_hit, lookup_data); end
        serve_memory(2, 200, to);
        checks++; if (to || wr_addr_q.size() != 2) begin errors++;
            $display("FAIL dup_count: writes=%0d timeout=%0b expected 2/0", wr_addr_q.size(), to); end
        else begin
            checks++; if (wr_addr_q[1] !== 16'h0300 || wr_data_q[1] !== pattern(16'hBBBB)) begin errors++;
                $display("FAIL dup_data: addr=%0h data=%0h expected 0300/B", wr_addr_q[1], wr_data_q[1]); end
        end
    endtask

    task automatic test_take_during_write();
        bit to;
        apply_reset();
        set_push(1, 16'h0400, pattern(16'hD400));
        tick();
        drive_idle();
        tick();
        lookup_addr = 16'h0400;
        lookup_take = 1;
        #1;
        checks++; if (mem_write !== 1 || lookup_hit !== 1) begin errors++;
            $display("FAIL twrite_hit: write=%0b hit=%0b expected 1/1", mem_write, lookup_hit); end
        tick();
        lookup_take = 0;
        #1;
        checks++; if (lookup_hit !== 0 || mem_write !== 1 || mem_addr !== 16'h0400 || mem_wdata !== pattern(16'hD400)) begin errors++;
            $display("FAIL twrite_held: hit=%0b write=%0b addr=%0h expected 0/1/0400", lookup_hit, mem_write, mem_addr); end
        serve_memory(2, 100, to);
        checks++; if (to || wr_addr_q.size() != 1 || empty !== 1) begin errors++;
            $display("FAIL twrite_done: writes=%0d timeout=%0b empty=%0b expected 1/0/1", wr_addr_q.size(), to, empty); end
    endtask

    task automatic test_full_boundary();
        bit to;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_push(1, 16'(16'h0500 + 16'h20 * i), pattern(16'(16'hE000 + i)));
            tick();
        end
        drive_idle();
        set_push(1, 16'h0580, pattern(16'hE004));
        mem_resp = 1;
        #1;
        checks++; if (used !== 4 || mem_write !== 1 || evict_ready !== 0) begin errors++;
            $display("FAIL full_reject: used=%0d write=%0b ready=%0b expected 4/1/0", used, mem_write, evict_ready); end
        tick();
        mem_resp = 0;
        #1;
        checks++; if (used !== 3 || evict_ready !== 1) begin errors++;
            $display("FAIL full_after_pop: used=%0d ready=%0b expected 3/1", used, evict_ready); end
        tick();
        drive_idle();
        checks++; if (used !== 4) begin errors++;
            $display("FAIL full_accept: used=%0d expected 4", used); end
        serve_memory(2, 200, to);
        checks++; if (to || wr_addr_q.size() != 4) begin errors++;
            $display("FAIL full_drain_count: writes=%0d timeout=%0b expected 4/0", wr_addr_q.size(), to); end
        else begin
            checks++; if (wr_addr_q[3] !== 16'h0580 || wr_data_q[3] !== pattern(16'hE004)) begin errors++;
                $display("FAIL full_drain_last: addr=%0h expected 0580", wr_addr_q[3]); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            evict_valid = ($urandom_range(0, 99) < 45);
            evict_dirty = 1'($urandom_range(0, 1));
            evict_addr  = rand_addr();
            evict_data  = rand_data();
            lookup_addr = ($urandom_range(0, 2) == 0) ? evict_addr : rand_addr();
            lookup_take = ($urandom_range(0, 99) < 25);
            mem_resp    = ($urandom_range(0, 99) < 35);
            #1;
            model_outputs();
            checks++; if (used !== mq.size() || empty !== (mq.size() == 0) || evict_ready !== (mq.size() < DEPTH)) begin errors++;
                $display("FAIL rand_status c=%0d: used=%0d empty=%0b ready=%0b expected used %0d", c, used, empty, evict_ready, mq.size()); end
            checks++; if (lookup_hit !== m_hit || lookup_data !== m_ldata) begin errors++;
                $display("FAIL rand_lookup c=%0d: hit=%0b data=%0h expected %0b/%0h", c, lookup_hit, lookup_data, m_hit, m_ldata); end
            if (m_hit) begin
                checks++; if (lookup_dirty !== m_ldirty) begin errors++;
                    $display("FAIL rand_dirty c=%0d: dirty=%0b expected %0b", c, lookup_dirty, m_ldirty); end
            end
            checks++; if (mem_write !== m_writing) begin errors++;
                $display("FAIL rand_mem_write c=%0d: write=%0b expected %0b", c, mem_write, m_writing); end
            if (m_writing) begin
                checks++; if (mem_addr !== m_maddr || mem_wdata !== m_mdata) begin errors++;
                    $display("FAIL rand_mem_data c=%0d: addr=%0h expected %0h", c, mem_addr, m_maddr); end
            end
            tick();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        reset_n = 0;
        model_reset();
        test_reset();
        test_fill_drain();
        test_clean_take();
        test_duplicate();
        test_take_during_write();
        test_full_boundary();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
